// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared FSM encoding and default sizing for the job dispatcher
package dispatcher_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_NOPS    = 4;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/job_fifo.sv
// rtl/job_fifo.sv - circular job queue holding packed operand sets
module job_fifo
   import dispatcher_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH * DEF_NOPS,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full queue never accepts, and popping an empty queue is a no-op
   assign ready   = (count < FULL);
   assign do_push = push && ready;
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally at DEPTH; count only moves on an unpaired push or pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/job_dispatcher.sv
// rtl/job_dispatcher.sv - queues jobs and runs each through start, wait-with-timeout and result handoff
module job_dispatcher
   import dispatcher_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NOPS    = DEF_NOPS,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NOPS*WIDTH-1:0]    in_data,
   input  logic                     op_ready,
   output logic                     start,
   output logic [NOPS*WIDTH-1:0]    operands,
   input  logic                     done,
   input  logic [WIDTH-1:0]         result,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic                     res_err,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int DW = NOPS * WIDTH;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   wait_cnt;
   logic [DW-1:0]   head;
   logic            pop;
   logic            take_done;
   logic            take_timeout;

   job_fifo #(
      .WIDTH (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .ready     (in_ready)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state; done wins over the timeout when both land on the last wait cycle
   always_comb begin
      state_next   = state;
      pop          = 1'b0;
      take_done    = 1'b0;
      take_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if ((fifo_count != '0) && op_ready) begin
               pop        = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: state_next = ST_WAIT;
         ST_WAIT: begin
            if (done) begin
               take_done  = 1'b1;
               state_next = ST_OUT;
            end else if (wait_cnt == LAST_WAIT) begin
               take_timeout = 1'b1;
               state_next   = ST_OUT;
            end
         end
         ST_OUT: begin
            if (res_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Operand latch on pop, wait-cycle counter, and result/error capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operands <= '0;
         wait_cnt <= '0;
         res_data <= '0;
         res_err  <= 1'b0;
      end else begin
         if (pop) operands <= head;
         if (state == ST_START)     wait_cnt <= '0;
         else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (take_done) begin
            res_data <= result;
            res_err  <= 1'b0;
         end else if (take_timeout) begin
            res_data <= '0;
            res_err  <= 1'b1;
         end
      end
   end

   assign start     = (state == ST_START);
   assign res_valid = (state == ST_OUT);
   assign busy      = (state != ST_IDLE);

endmodule
